// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder-side producer, the sum accumulator and its consumer.
// master drives the sums and takes the results; slave is the accumulator itself.
interface sum_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_sum;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [7:0]       out_count;
  logic             out_overflow;

  modport master (
    output in_valid, in_sum, flush, out_ready,
    input  in_ready, out_valid, out_total, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_sum, flush, out_ready,
    output in_ready, out_valid, out_total, out_count, out_overflow
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates blocks of COUNT adder sums (or fewer on flush) and holds the block
// total, count and wrap flag on a registered output until the consumer takes it.
module sum_accumulator #(
  parameter int ACC_W = 12,
  parameter int COUNT = 8
) (
  input logic              clk,
  input logic              rst_n,
  sum_accumulator_if.slave bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [7:0] COUNT_M1 = 8'(COUNT - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [7:0]       count_q, count_d;
  logic             ovo_q, ovo_d;

  logic             accept;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] acc_post;
  logic [7:0]       cnt_post;
  logic             ovf_post;
  logic             close;

  assign accept = (state_q == ACCUM) && bus.in_valid;

  // One extra bit so the carry out of the accumulator marks a wrap.
  assign sum_w    = {1'b0, acc_q} + {{(ACC_W - 6){1'b0}}, bus.in_sum};
  assign acc_post = accept ? sum_w[ACC_W-1:0] : acc_q;
  assign ovf_post = ovf_q | (accept & sum_w[ACC_W]);
  assign cnt_post = cnt_q + {7'd0, accept};

  // A flush only closes a block that holds at least one sample after this cycle.
  assign close = (state_q == ACCUM) &&
                 ((accept && (cnt_q == COUNT_M1)) || (bus.flush && (cnt_post != 8'd0)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    total_d = total_q;
    count_d = count_q;
    ovo_d   = ovo_q;
    case (state_q)
      ACCUM: begin
        if (close) begin
          total_d = acc_post;
          count_d = cnt_post;
          ovo_d   = ovf_post;
          vld_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
          state_d = HOLD;
        end else begin
          acc_d = acc_post;
          cnt_d = cnt_post;
          ovf_d = ovf_post;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      total_q <= '0;
      count_q <= 8'd0;
      ovo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      total_q <= total_d;
      count_q <= count_d;
      ovo_q   <= ovo_d;
    end
  end

  assign bus.in_ready     = (state_q == ACCUM);
  assign bus.out_valid    = vld_q;
  assign bus.out_total    = total_q;
  assign bus.out_count    = count_q;
  assign bus.out_overflow = ovo_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances (default, narrow accumulator, short block)
// driven from shared stimulus, with expected results checked by a scoreboard monitor.
module tb_sum_accumulator;

  typedef struct {
    int   total;
    int   count;
    logic ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] sel;
  logic       in_valid;
  logic [6:0] in_sum;
  logic       flush;
  logic       out_ready;

  int checks;
  int failures;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  sum_accumulator_if #(.ACC_W(12)) ifa ();
  sum_accumulator_if #(.ACC_W(9))  ifb ();
  sum_accumulator_if #(.ACC_W(12)) ifc ();

  assign ifa.in_valid  = in_valid && (sel == 2'd0);
  assign ifa.flush     = flush && (sel == 2'd0);
  assign ifa.in_sum    = in_sum;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid && (sel == 2'd1);
  assign ifb.flush     = flush && (sel == 2'd1);
  assign ifb.in_sum    = in_sum;
  assign ifb.out_ready = out_ready;
  assign ifc.in_valid  = in_valid && (sel == 2'd2);
  assign ifc.flush     = flush && (sel == 2'd2);
  assign ifc.in_sum    = in_sum;
  assign ifc.out_ready = out_ready;

  sum_accumulator #(.ACC_W(12), .COUNT(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  sum_accumulator #(.ACC_W(9),  .COUNT(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  sum_accumulator #(.ACC_W(12), .COUNT(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  logic rdy_s;
  assign rdy_s = (sel == 2'd0) ? ifa.in_ready : (sel == 2'd1) ? ifb.in_ready : ifc.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int t, input int c, input logic o);
    exp_t e;
    e.total = t;
    e.count = c;
    e.ovf   = o;
    case (sel)
      2'd0:    qa.push_back(e);
      2'd1:    qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // Present one sample; returns one time unit after the accepting edge.
  task automatic send(input logic [6:0] v, input logic fl);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_sum   = v;
    flush    = fl;
    while (!rdy_s && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pop_cmp(input string who, input int tot, input int cnt, input logic ov,
                         input int k);
    exp_t e;
    int   sz;
    sz = (k == 0) ? qa.size() : (k == 1) ? qb.size() : qc.size();
    if (sz == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected: got output total=%0d count=%0d expected none", who, tot, cnt);
    end else begin
      if (k == 0)      e = qa.pop_front();
      else if (k == 1) e = qb.pop_front();
      else             e = qc.pop_front();
      chk({who, "_total"}, tot, e.total);
      chk({who, "_count"}, cnt, e.count);
      chk({who, "_ovf"}, int'(ov), int'(e.ovf));
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifa.out_valid && ifa.out_ready)
          pop_cmp("a", int'(ifa.out_total), int'(ifa.out_count), ifa.out_overflow, 0);
        if (ifb.out_valid && ifb.out_ready)
          pop_cmp("b", int'(ifb.out_total), int'(ifb.out_count), ifb.out_overflow, 1);
        if (ifc.out_valid && ifc.out_ready)
          pop_cmp("c", int'(ifc.out_total), int'(ifc.out_count), ifc.out_overflow, 2);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int gaps[4];
    checks    = 0;
    failures  = 0;
    sel       = 2'd0;
    in_valid  = 1'b0;
    in_sum    = 7'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", int'(ifa.out_valid), 0);
    chk("rst_out_total", int'(ifa.out_total), 0);
    chk("rst_out_count", int'(ifa.out_count), 0);
    chk("rst_out_ovf", int'(ifa.out_overflow), 0);
    chk("rst_in_ready", int'(ifa.in_ready), 1);
    chk("rst_b_valid", int'(ifb.out_valid), 0);
    chk("rst_c_valid", int'(ifc.out_valid), 0);

    // Full block of 10s; in_ready drops for exactly the one HOLD cycle.
    push(80, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(7'd10, 1'b0);
    @(negedge clk);
    chk("blk1_valid_hi", int'(ifa.out_valid), 1);
    chk("blk1_ready_lo", int'(ifa.in_ready), 0);
    @(negedge clk);
    chk("blk1_valid_lo", int'(ifa.out_valid), 0);
    chk("blk1_ready_hi", int'(ifa.in_ready), 1);

    push(1008, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(7'd126, 1'b0);

    // Early flush coinciding with an accept, then a flush on an empty block.
    push(18, 4, 1'b0);
    send(7'd3, 1'b0);
    send(7'd4, 1'b0);
    send(7'd5, 1'b0);
    send(7'd6, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("empty_flush_v0", int'(ifa.out_valid), 0);
    @(negedge clk);
    chk("empty_flush_v1", int'(ifa.out_valid), 0);

    // Backpressured result: outputs hold while a new sample is offered and refused.
    out_ready = 1'b0;
    push(8, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(7'd1, 1'b0);
    in_valid = 1'b1;
    in_sum   = 7'd50;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(ifa.out_valid), 1);
      chk("hold_total", int'(ifa.out_total), 8);
      chk("hold_count", int'(ifa.out_count), 8);
      chk("hold_ready", int'(ifa.in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("after_hs_ready", int'(ifa.in_ready), 1);
    chk("after_hs_valid", int'(ifa.out_valid), 0);
    push(16, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(7'd2, 1'b0);

    // Reset mid-block and during HOLD discards everything.
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(7'd3, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", int'(ifa.out_valid), 0);
    chk("midrst_total", int'(ifa.out_total), 0);
    chk("midrst_count", int'(ifa.out_count), 0);
    chk("midrst_ready", int'(ifa.in_ready), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(7'd4, 1'b0);
    @(negedge clk);
    chk("holdrst_pre_valid", int'(ifa.out_valid), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("holdrst_valid", int'(ifa.out_valid), 0);
    chk("holdrst_total", int'(ifa.out_total), 0);
    chk("holdrst_count", int'(ifa.out_count), 0);
    chk("holdrst_ready", int'(ifa.in_ready), 1);
    out_ready = 1'b1;
    push(16, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(7'd2, 1'b0);

    // Narrow accumulator: 1008 wraps to 496, then the flag clears on the next block.
    @(posedge clk);
    #1;
    sel = 2'd1;
    push(496, 8, 1'b1);
    for (int i = 0; i < 8; i++) send(7'd126, 1'b0);
    push(8, 8, 1'b0);
    for (int i = 0; i < 8; i++) send(7'd1, 1'b0);

    // Short blocks with idle gaps between samples.
    @(posedge clk);
    #1;
    sel     = 2'd2;
    gaps[0] = 2;
    gaps[1] = 5;
    gaps[2] = 3;
    gaps[3] = 4;
    push(28, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) @(posedge clk);
      #1;
      send(7'd7, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 6-bit ripple adder's 7-bit `sum` output. Accepts one 7-bit sum per valid/ready handshake, accumulates a block of `COUNT` sums (or fewer, on `flush`) into a wider register, then presents the block total, sample count and overflow flag on a registered output port until the consumer takes it. Used as the reduction stage behind the adder in the datapath.

## Interface
- `ACC_W`, 12, accumulator / total width in bits; legal range 7..32.
- `COUNT`, 8, number of sums per block; legal range 1..255.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  one clock; reset is synchronous and active-low.
- `in_valid`  input  1  `in_sum` holds a sum to accumulate.
- `in_ready`  output  1  block can accept a sum this cycle.
- `in_sum`  input  7  unsigned sum from the adder.
- `flush`  input  1  close the current block early; level-sampled in ACCUM.
- `out_valid`  output  1  total/count/overflow are valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_total`  output  ACC_W  block sum, modulo 2^ACC_W.
- `out_count`  output  8  number of sums in the block (1..COUNT).
- `out_overflow`  output  1  the true block sum exceeded 2^ACC_W−1.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- Internal registers: `acc` (ACC_W bits), `cnt` (8 bits), `ovf` (sticky, 1 bit).
- ACCUM:
  - `in_ready`=1.
  - Accept when `in_valid`=1: `acc`←`acc`+zero-extended `in_sum`. The carry out of bit ACC_W−1 sets `ovf`. `cnt`←`cnt`+1.
  - Close the block on either condition: an accept with `cnt`=COUNT−1, or `flush`=1 with the post-accept count ≥1.
  - On close: `out_total`, `out_count` and `out_overflow` load the post-accept values. `out_valid`←1. `acc`, `cnt` and `ovf` clear. Go to HOLD.
- Simultaneous `flush` and accept: the sample is included, then the block closes.
- `flush` with `cnt`=0 and no accept is ignored. No zero-length block is ever emitted.
- HOLD:
  - `in_ready`=0. Outputs are held stable.
  - On `out_valid`&&`out_ready`: `out_valid`←0, go to ACCUM.
- Arithmetic is unsigned. With default parameters the maximum total is 8×126=1008, so overflow cannot occur. Overflow is reachable only with a small ACC_W.
- `out_total` wraps modulo 2^ACC_W. `out_overflow` records whether any wrap occurred within the block.

## Timing
- Reset values (applied at a clock edge with `rst_n`=0):
  - State ACCUM.
  - `acc`, `cnt`, `ovf` = 0.
  - `out_valid` = 0, `out_total` = 0, `out_count` = 0, `out_overflow` = 0.
- `in_ready` is decoded combinationally from state only. It never depends on `in_valid` or `out_ready`.
- Latency: `out_valid` rises on the clock edge that accepts the closing sample (or samples `flush`). It is visible in the following cycle.
- Throughput: at least one bubble cycle per block. Minimum block period is COUNT accept cycles plus 1 HOLD cycle when `out_ready` is held at 1.
- The upstream side must hold `in_sum` stable while `in_valid`=1 and `in_ready`=0.
- While `out_valid`=1, outputs do not change until the handshake completes.
- Reset mid-block or during HOLD discards the partial block and any pending result. No output is produced for it.

## Test plan
- Reset, then 8 consecutive accepts of `in_sum`=10 with `out_ready`=1 → `out_valid` high for one cycle, `out_total`=80, `out_count`=8, `out_overflow`=0. `in_ready` low exactly one cycle.
- 8 accepts of 126 → `out_total`=1008, `out_count`=8. Repeat with ACC_W=9 → `out_total`=1008−512=496, `out_overflow`=1. The next block of 8×1 → `out_total`=8, `out_overflow`=0 (sticky flag cleared).
- Accept 3, 4, 5, then assert `flush` together with an accept of 6 → `out_total`=18, `out_count`=4. A `flush` pulse with `cnt`=0 → no `out_valid`.
- Complete a block with `out_ready`=0 for 5 cycles → `out_valid` and all outputs stable for 5 cycles, `in_ready`=0, and an `in_valid` offered meanwhile is not consumed. `out_ready`=1 → handshake completes, then `in_ready`=1 on the next cycle.
- Random `in_valid` gaps (4 accepts of 7 spread over 20 cycles) with COUNT=4 → `out_total`=28, `out_count`=4. Idle cycles do not change `acc` or `cnt`.
- Assert `rst_n`=0 after 5 accepts, and again during HOLD → all outputs 0 on the next cycle. A following full block of 8×2 → `out_total`=16 (no residue).
